gcd_arbiter: RTL and testbench
==============================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand/result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning max WAIT cycles before abort (used only with GCD_ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports REQ0/REQ1  input  1 each  requester job request, held until ACK.
REQ-006 The block SHALL have ports A0/B0, A1/B1  input  W each  requester operands, stable while REQ high.
REQ-007 The block SHALL have ports ACK0/ACK1  output  1 each  one-cycle job-accepted pulse.
REQ-008 The block SHALL have ports DONE0/DONE1  output  1 each  one-cycle result-valid pulse.
REQ-009 The block SHALL have ports Y0/Y1  output  W each  result, held until that requester's next DONE.
REQ-010 The block SHALL have ports ERR0/ERR1  output  1 each  error status, qualified by DONE.
REQ-011 The block SHALL have ports GCD_START  output  1,  GCD_A/GCD_B  output  W  core command.
REQ-012 The block SHALL have ports GCD_Y  input  W,  GCD_DONE  input  1,  GCD_ERROR  input  1  core response.
REQ-013 The block SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-014 The block SHALL have port TO_FLAG  output  1  sticky timeout indicator.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; all outputs SHALL be Moore-decoded from state, owner, and registered data.
REQ-016 In IDLE with any REQ sampled high at a rising edge, the block SHALL select an owner, capture its A/B into registers, and enter ISSUE.
REQ-017 In ISSUE (exactly one cycle), ACK[owner]=1, GCD_START=1, GCD_A/GCD_B=captured operands; next state WAIT.
REQ-018 In WAIT, GCD_A/GCD_B SHALL stay at the captured values and GCD_START=0; GCD_DONE sampled high SHALL capture GCD_Y/GCD_ERROR and move to RESP.
REQ-019 In RESP (exactly one cycle), DONE[owner]=1 with Y[owner]/ERR[owner] valid; next state IDLE.
REQ-020 The non-owner's Y/ERR SHALL be unchanged by a job it does not own.
REQ-021 Arbitration SHALL be round-robin over 2 requesters: the last-granted requester gets lower priority; after reset, requester 0 has priority.
REQ-022 Overhead SHALL be 3 cycles beyond core latency: REQ edge to ACK is 1 cycle; GCD_DONE edge to DONE is 1 cycle; RESP to next ISSUE is at least 1 cycle.
REQ-023 GCD_DONE in IDLE, ISSUE, or RESP SHALL be ignored.
REQ-024 A REQ held high through RESP SHALL be arbitrated in the following IDLE cycle; it SHALL be neither lost nor double-accepted.
REQ-025 GCD_ERROR SHALL pass through to ERR[owner] unmodified; Y[owner] SHALL equal GCD_Y even when an error occurs.

Reset
REQ-026 RST high SHALL immediately force IDLE, owner/priority pointer to 0, and all outputs, Y0/Y1, captured operands, and TO_FLAG to 0, including mid-WAIT.
REQ-027 After RST deasserts, the first IDLE edge SHALL arbitrate normally; the aborted job SHALL produce no DONE.

Configuration
REQ-028 With GCD_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle; reaching TIMEOUT without GCD_DONE SHALL force RESP with ERR[owner]=1, Y[owner]=0, and TO_FLAG set (sticky until RST).
REQ-029 Without GCD_ARB_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL be unbounded, TO_FLAG SHALL be tied 0, and the TIMEOUT parameter SHALL be unused.

Structure
REQ-030 Package gcd_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the owner ID constants (REQ_ID0=0, REQ_ID1=1), and the default W/TIMEOUT constants.
REQ-031 Sub-module gcd_rr_arb SHALL implement the 2-way round-robin pick (req[1:0], update pulse -> grant index), with its pointer reset to 0.
REQ-032 The GCD core SHALL be instantiated outside this block and connected through the GCD_* ports.

Verification
REQ-033 REQ0 with (21,6) -> ACK0 one cycle later, DONE0 with Y0=3, ERR0=0; Y1/DONE1 untouched.
REQ-034 REQ0 (29,8) and REQ1 (99,11) raised in the same cycle after reset -> requester 0 served first (Y0=1), then requester 1 (Y1=11); no overlap of GCD_START.
REQ-035 Both requesters continuously requesting (75,60) and (103,103) -> grants alternate 0,1,0,1; Y0=15, Y1=103 every round.
REQ-036 REQ1 with (0,5) and a core asserting GCD_ERROR -> DONE1 with ERR1=1; the next job completes with ERR1=0.
REQ-037 GCD_ARB_TIMEOUT_EN, TIMEOUT=16, stub core never raises DONE -> DONE0 17 cycles after GCD_START, ERR0=1, Y0=0, TO_FLAG=1; without the macro, BUSY stays 1.
REQ-038 RST pulsed during WAIT -> BUSY=0 and all outputs 0 immediately; no DONE for the aborted job; a fresh REQ1 (21,6) then yields Y1=3.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the two-requester GCD arbiter.
package gcd_arb_pkg;

    localparam int unsigned GCD_ARB_W_DEF       = 8;
    localparam int unsigned GCD_ARB_TIMEOUT_DEF = 255;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } gcd_arb_state_e;

endpackage

// File: rtl/gcd_rr_arb.sv
// Two-way round-robin pick; the requester granted last drops to lower priority.
module gcd_rr_arb
    import gcd_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic prio_q;

    always_comb begin
        grant = prio_q;
        if (!req[prio_q] && req[~prio_q]) begin
            grant = ~prio_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= REQ_ID0;
        end else if (update) begin
            prio_q <= ~grant;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one external GCD core between two requesters with round-robin arbitration.
// Optional WAIT timeout abort is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int unsigned W       = GCD_ARB_W_DEF,
    parameter int unsigned TIMEOUT = GCD_ARB_TIMEOUT_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] B0,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] B1,
    output logic         ACK0,
    output logic         ACK1,
    output logic         DONE0,
    output logic         DONE1,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic         ERR0,
    output logic         ERR1,
    output logic         GCD_START,
    output logic [W-1:0] GCD_A,
    output logic [W-1:0] GCD_B,
    input  logic [W-1:0] GCD_Y,
    input  logic         GCD_DONE,
    input  logic         GCD_ERROR,
    output logic         BUSY,
    output logic         TO_FLAG
);

    gcd_arb_state_e state_q, state_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   y0_q, y0_d, y1_q, y1_d;
    logic           err0_q, err0_d, err1_q, err1_d;
    logic           grant, arb_update, timeout_hit;

    gcd_rr_arb u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    ({REQ1, REQ0}),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        err0_d     = err0_q;
        err1_d     = err1_q;
        arb_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    arb_update = 1'b1;
                    owner_d    = grant;
                    a_d        = (grant == REQ_ID1) ? A1 : A0;
                    b_d        = (grant == REQ_ID1) ? B1 : B0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (GCD_DONE) begin
                    state_d = RESP;
                    if (owner_q == REQ_ID1) begin
                        y1_d   = GCD_Y;
                        err1_d = GCD_ERROR;
                    end else begin
                        y0_d   = GCD_Y;
                        err0_d = GCD_ERROR;
                    end
                end else if (timeout_hit) begin
                    // Aborted job reports an error with a zero result.
                    state_d = RESP;
                    if (owner_q == REQ_ID1) begin
                        y1_d   = '0;
                        err1_d = 1'b1;
                    end else begin
                        y0_d   = '0;
                        err0_d = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= REQ_ID0;
            a_q     <= '0;
            b_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic          to_q;

    assign timeout_hit = (state_q == WAIT) && !GCD_DONE && (32'(cnt_q) == TIMEOUT - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (timeout_hit) begin
                to_q <= 1'b1;
            end
        end
    end

    assign TO_FLAG = to_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign TO_FLAG        = 1'b0;
`endif

    assign ACK0      = (state_q == ISSUE) && (owner_q == REQ_ID0);
    assign ACK1      = (state_q == ISSUE) && (owner_q == REQ_ID1);
    assign DONE0     = (state_q == RESP) && (owner_q == REQ_ID0);
    assign DONE1     = (state_q == RESP) && (owner_q == REQ_ID1);
    assign Y0        = y0_q;
    assign Y1        = y1_q;
    assign ERR0      = err0_q;
    assign ERR1      = err1_q;
    assign GCD_START = (state_q == ISSUE);
    assign GCD_A     = a_q;
    assign GCD_B     = b_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed self-checking bench for gcd_arbiter with a behavioural GCD core stub.
module tb_gcd_arbiter;

    localparam int W = 8;
`ifdef GCD_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif
    localparam int LAT = 2;

    logic         CLK = 1'b0, RST = 1'b1;
    logic         REQ0 = 1'b0, REQ1 = 1'b0;
    logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic         ACK0, ACK1, DONE0, DONE1, ERR0, ERR1;
    logic [W-1:0] Y0, Y1, GCD_A, GCD_B;
    logic         GCD_START, BUSY, TO_FLAG;
    logic [W-1:0] GCD_Y = '0;
    logic         GCD_DONE = 1'b0, GCD_ERROR = 1'b0;

    int checks = 0;
    int errors = 0;
    logic hang = 1'b0;

    gcd_arbiter #(.W(W), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .ACK0(ACK0), .ACK1(ACK1), .DONE0(DONE0), .DONE1(DONE1),
        .Y0(Y0), .Y1(Y1), .ERR0(ERR0), .ERR1(ERR1),
        .GCD_START(GCD_START), .GCD_A(GCD_A), .GCD_B(GCD_B),
        .GCD_Y(GCD_Y), .GCD_DONE(GCD_DONE), .GCD_ERROR(GCD_ERROR),
        .BUSY(BUSY), .TO_FLAG(TO_FLAG)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core stub: fixed latency, flags an error (result 0xEE) on a zero operand.
    initial begin : core_stub
        int cnt;
        logic [W-1:0] sa, sb;
        cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            GCD_DONE = 1'b0;
            if (RST) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    GCD_DONE  = 1'b1;
                    GCD_ERROR = (sa == 0) || (sb == 0);
                    GCD_Y     = GCD_ERROR ? 8'hEE : euclid(sa, sb);
                end
            end else if (GCD_START && !hang) begin
                sa  = GCD_A;
                sb  = GCD_B;
                cnt = LAT;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (BUSY !== 1'b0 || GCD_START !== 1'b0 || ACK0 !== 1'b0 || DONE1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b start=%b ack0=%b done1=%b want 0000",
                     BUSY, GCD_START, ACK0, DONE1);
        end
        checks++;
        if (Y0 !== 8'd0 || Y1 !== 8'd0 || GCD_A !== 8'd0 || TO_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL reset_data y0=%0d y1=%0d gcd_a=%0d to=%b want 0", Y0, Y1, GCD_A, TO_FLAG);
        end
        RST = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bit saw_done1;
        REQ0 = 1'b1; A0 = 8'd21; B0 = 8'd6;
        tick();
        checks++;
        if (ACK0 !== 1'b1 || ACK1 !== 1'b0 || GCD_START !== 1'b1 || GCD_A !== 8'd21 || GCD_B !== 8'd6) begin
            errors++;
            $display("FAIL single_ack ack0=%b ack1=%b start=%b a=%0d b=%0d want 1 0 1 21 6",
                     ACK0, ACK1, GCD_START, GCD_A, GCD_B);
        end
        REQ0 = 1'b0;
        tick();
        checks++;
        if (GCD_START !== 1'b0 || GCD_A !== 8'd21 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_wait start=%b a=%0d busy=%b want 0 21 1", GCD_START, GCD_A, BUSY);
        end
        n = 1;
        saw_done1 = 1'b0;
        while (!DONE0 && n < 20) begin
            tick();
            n++;
            if (DONE1) saw_done1 = 1'b1;
        end
        checks++;
        if (n !== LAT + 1) begin
            errors++;
            $display("FAIL single_latency ack_to_done=%0d want %0d", n, LAT + 1);
        end
        checks++;
        if (Y0 !== 8'd3 || ERR0 !== 1'b0 || Y1 !== 8'd0 || saw_done1) begin
            errors++;
            $display("FAIL single_result y0=%0d err0=%b y1=%0d done1=%b want 3 0 0 0",
                     Y0, ERR0, Y1, saw_done1);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0 || DONE0 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b done0=%b want 0 0", BUSY, DONE0);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        REQ0 = 1'b1; A0 = 8'd29; B0 = 8'd8;
        REQ1 = 1'b1; A1 = 8'd99; B1 = 8'd11;
        tick();
        checks++;
        if (ACK0 !== 1'b1 || ACK1 !== 1'b0) begin
            errors++;
            $display("FAIL simul_first ack0=%b ack1=%b want 1 0", ACK0, ACK1);
        end
        REQ0 = 1'b0;
        n = 0;
        while (!DONE0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (DONE0 !== 1'b1 || Y0 !== 8'd1) begin
            errors++;
            $display("FAIL simul_y0 done0=%b y0=%0d want 1 1", DONE0, Y0);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0 || GCD_START !== 1'b0) begin
            errors++;
            $display("FAIL simul_gap busy=%b start=%b want 0 0", BUSY, GCD_START);
        end
        tick();
        checks++;
        if (ACK1 !== 1'b1 || GCD_A !== 8'd99 || GCD_B !== 8'd11) begin
            errors++;
            $display("FAIL simul_second ack1=%b a=%0d b=%0d want 1 99 11", ACK1, GCD_A, GCD_B);
        end
        REQ1 = 1'b0;
        n = 0;
        while (!DONE1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (DONE1 !== 1'b1 || Y1 !== 8'd11 || Y0 !== 8'd1) begin
            errors++;
            $display("FAIL simul_y1 done1=%b y1=%0d y0=%0d want 1 11 1", DONE1, Y1, Y0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1:0] got;
        REQ0 = 1'b1; A0 = 8'd75; B0 = 8'd60;
        REQ1 = 1'b1; A1 = 8'd103; B1 = 8'd103;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!ACK0 && !ACK1 && n < 20) begin
                tick();
                n++;
            end
            got = {ACK1, ACK0};
            checks++;
            if (got !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL b2b_grant round=%0d ack1ack0=%b want %b", g, got,
                         (g % 2 == 0) ? 2'b01 : 2'b10);
            end
            n = 0;
            while (!DONE0 && !DONE1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if ((g % 2 == 0) ? (DONE0 !== 1'b1 || Y0 !== 8'd15) : (DONE1 !== 1'b1 || Y1 !== 8'd103)) begin
                errors++;
                $display("FAIL b2b_result round=%0d done0=%b y0=%0d done1=%b y1=%0d want y0=15/y1=103",
                         g, DONE0, Y0, DONE1, Y1);
            end
            tick();
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_error();
        int n;
        REQ1 = 1'b1; A1 = 8'd0; B1 = 8'd5;
        n = 0;
        while (!ACK1 && n < 20) begin
            tick();
            n++;
        end
        REQ1 = 1'b0;
        while (!DONE1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (DONE1 !== 1'b1 || ERR1 !== 1'b1 || Y1 !== 8'hEE || ERR0 !== 1'b0) begin
            errors++;
            $display("FAIL error_flag done1=%b err1=%b y1=%h err0=%b want 1 1 ee 0",
                     DONE1, ERR1, Y1, ERR0);
        end
        tick();
        REQ1 = 1'b1; A1 = 8'd21; B1 = 8'd6;
        n = 0;
        while (!ACK1 && n < 20) begin
            tick();
            n++;
        end
        REQ1 = 1'b0;
        while (!DONE1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (DONE1 !== 1'b1 || ERR1 !== 1'b0 || Y1 !== 8'd3) begin
            errors++;
            $display("FAIL error_clear done1=%b err1=%b y1=%0d want 1 0 3", DONE1, ERR1, Y1);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        hang = 1'b1;
        REQ0 = 1'b1; A0 = 8'd21; B0 = 8'd6;
        n = 0;
        while (!GCD_START && n < 20) begin
            tick();
            n++;
        end
        REQ0 = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
        n = 0;
        while (!DONE0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TMO + 1 || ERR0 !== 1'b1 || Y0 !== 8'd0 || TO_FLAG !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort cycles=%0d err0=%b y0=%0d to=%b want %0d 1 0 1",
                     n, ERR0, Y0, TO_FLAG, TMO + 1);
        end
        tick();
`else
        repeat (40) begin
            tick();
            checks++;
            if (BUSY !== 1'b1 || DONE0 !== 1'b0 || TO_FLAG !== 1'b0) begin
                errors++;
                $display("FAIL timeout_unbounded busy=%b done0=%b to=%b want 1 0 0",
                         BUSY, DONE0, TO_FLAG);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        int n;
        bit saw_done;
        hang = 1'b1;
        do_reset();
        REQ1 = 1'b1; A1 = 8'd50; B1 = 8'd10;
        tick();
        REQ1 = 1'b0;
        tick();
        tick();
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midwait_busy busy=%b want 1", BUSY);
        end
        #3 RST = 1'b1;
        #1;
        checks++;
        if (BUSY !== 1'b0 || GCD_A !== 8'd0 || GCD_B !== 8'd0 || Y0 !== 8'd0 || Y1 !== 8'd0 ||
            ERR0 !== 1'b0 || ERR1 !== 1'b0 || TO_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL midwait_async busy=%b a=%0d b=%0d y0=%0d y1=%0d err=%b%b to=%b want all 0",
                     BUSY, GCD_A, GCD_B, Y0, Y1, ERR1, ERR0, TO_FLAG);
        end
        tick();
        RST = 1'b0;
        hang = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            if (DONE0 || DONE1 || BUSY) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midwait_no_done activity seen after reset, want none");
        end
        REQ1 = 1'b1; A1 = 8'd21; B1 = 8'd6;
        tick();
        checks++;
        if (ACK1 !== 1'b1) begin
            errors++;
            $display("FAIL midwait_ack ack1=%b want 1", ACK1);
        end
        REQ1 = 1'b0;
        n = 0;
        while (!DONE1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (DONE1 !== 1'b1 || Y1 !== 8'd3 || ERR1 !== 1'b0) begin
            errors++;
            $display("FAIL midwait_fresh done1=%b y1=%0d err1=%b want 1 3 0", DONE1, Y1, ERR1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_error();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
